led_band_mem_ctrl: RTL

- Sequencer for the dual-port LED band memory: 128-bit write port, 8-bit read port, one clock.
- Write side: packs an incoming pixel byte stream into 16-byte words and writes them into one half (bank) of the memory.
- Read side: on each column trigger, streams that column's bytes out of the other bank.
- Banks are ping-ponged at frame boundaries, so the LED drivers never read a frame that is still being written.

---
 rtl/led_band_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/led_band_mem_ctrl.sv
// led_band_mem_ctrl: packs a pixel byte stream into 128-bit words for one memory
// bank while streaming per-column bytes out of the other bank; the banks are
// ping-ponged at frame boundaries.
// Optional macro LED_MEM_CTRL_STATS_EN adds the drop_cnt statistics output.
module led_band_mem_ctrl #(
    parameter int unsigned W_ADDR_WIDTH     = 11,
    parameter int unsigned R_ADDR_WIDTH     = 15,
    parameter int unsigned BYTES_PER_COLUMN = 48,
    parameter int unsigned COLUMNS          = 128,
    parameter int unsigned COL_WIDTH        = 7
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_sof,
    output logic                    in_ready,
    output logic [W_ADDR_WIDTH-1:0] mem_w_addr,
    output logic [127:0]            mem_w_data,
    output logic                    mem_w_enable,
    output logic [R_ADDR_WIDTH-1:0] mem_r_addr,
    output logic                    mem_r_enable,
    input  logic [7:0]              mem_r_data,
    input  logic                    col_start,
    input  logic [COL_WIDTH-1:0]    col_idx,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    output logic                    col_busy,
`ifdef LED_MEM_CTRL_STATS_EN
    output logic [15:0]             drop_cnt,
`endif
    output logic                    frame_swapped
);

    localparam int unsigned FRAME_BYTES = BYTES_PER_COLUMN * COLUMNS;
    localparam int unsigned FRAME_WORDS = FRAME_BYTES / 16;
    localparam int unsigned WC_W        = W_ADDR_WIDTH - 1;
    localparam int unsigned RB_W        = R_ADDR_WIDTH - 1;
    localparam int unsigned CNT_W       = $clog2(BYTES_PER_COLUMN + 1);

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              byte_cnt_q, byte_cnt_d;
    logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
    logic [127:0]            pack_q, pack_d;
    logic                    wbank_q, wbank_d;
    logic                    rbank_q, rbank_d;
    logic                    swap_pending_q, swap_pending_d;
    logic                    in_ready_q, in_ready_d;
    logic [W_ADDR_WIDTH-1:0] mem_w_addr_q, mem_w_addr_d;
    logic [127:0]            mem_w_data_q, mem_w_data_d;
    logic                    mem_w_enable_q, mem_w_enable_d;
    logic [R_ADDR_WIDTH-1:0] mem_r_addr_q, mem_r_addr_d;
    logic                    mem_r_enable_q, mem_r_enable_d;
    logic                    out_valid_q, out_valid_d;
    logic                    col_busy_q, col_busy_d;
    logic                    frame_swapped_q, frame_swapped_d;
    logic [RB_W-1:0]         base_q, base_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;

    logic                    accept;
    logic                    swap;
    logic                    col_ok;

    assign accept = in_valid && in_ready_q;
    assign swap   = swap_pending_q && !col_busy_q;
    assign col_ok = ({1'b0, col_idx} < (COL_WIDTH + 1)'(COLUMNS));

    // Next-state for the write packer, bank swap and column read FSM
    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        word_cnt_d      = word_cnt_q;
        pack_d          = pack_q;
        wbank_d         = wbank_q;
        rbank_d         = rbank_q;
        swap_pending_d  = swap_pending_q;
        in_ready_d      = in_ready_q;
        mem_w_addr_d    = mem_w_addr_q;
        mem_w_data_d    = mem_w_data_q;
        mem_w_enable_d  = 1'b0;
        mem_r_addr_d    = mem_r_addr_q;
        mem_r_enable_d  = 1'b0;
        out_valid_d     = mem_r_enable_q;
        col_busy_d      = col_busy_q;
        frame_swapped_d = 1'b0;
        base_d          = base_q;
        rd_cnt_d        = rd_cnt_q;

        if (accept) begin
            if (in_sof) begin
                // start of frame restarts packing; any partial word is dropped
                pack_d[7:0] = in_data;
                byte_cnt_d  = 4'd1;
                word_cnt_d  = '0;
            end else begin
                pack_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                if (byte_cnt_q == 4'd15) begin
                    mem_w_enable_d = 1'b1;
                    mem_w_addr_d   = {wbank_q, word_cnt_q};
                    mem_w_data_d   = pack_d;
                    byte_cnt_d     = 4'd0;
                    word_cnt_d     = word_cnt_q + WC_W'(1);
                    // last word of the frame: stall input until the banks swap
                    if (word_cnt_q == WC_W'(FRAME_WORDS - 1)) begin
                        swap_pending_d = 1'b1;
                        in_ready_d     = 1'b0;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + 4'd1;
                end
            end
        end

        if (swap) begin
            wbank_d         = ~wbank_q;
            rbank_d         = ~rbank_q;
            frame_swapped_d = 1'b1;
            swap_pending_d  = 1'b0;
            word_cnt_d      = '0;
            in_ready_d      = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // first read goes out immediately, using the post-swap read bank
                if (col_start && col_ok) begin
                    state_d        = ST_READ;
                    col_busy_d     = 1'b1;
                    base_d         = RB_W'(col_idx) * RB_W'(BYTES_PER_COLUMN);
                    mem_r_enable_d = 1'b1;
                    mem_r_addr_d   = {rbank_d, base_d};
                    rd_cnt_d       = CNT_W'(1);
                end
            end
            ST_READ: begin
                if (rd_cnt_q != CNT_W'(BYTES_PER_COLUMN)) begin
                    mem_r_enable_d = 1'b1;
                    mem_r_addr_d   = {rbank_q, base_q + RB_W'(rd_cnt_q)};
                    rd_cnt_d       = rd_cnt_q + CNT_W'(1);
                end else if (!mem_r_enable_q) begin
                    // last byte is on out_data this cycle
                    state_d    = ST_IDLE;
                    col_busy_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= ST_IDLE;
            byte_cnt_q      <= '0;
            word_cnt_q      <= '0;
            pack_q          <= '0;
            wbank_q         <= 1'b0;
            rbank_q         <= 1'b1;
            swap_pending_q  <= 1'b0;
            in_ready_q      <= 1'b1;
            mem_w_addr_q    <= '0;
            mem_w_data_q    <= '0;
            mem_w_enable_q  <= 1'b0;
            mem_r_addr_q    <= '0;
            mem_r_enable_q  <= 1'b0;
            out_valid_q     <= 1'b0;
            col_busy_q      <= 1'b0;
            frame_swapped_q <= 1'b0;
            base_q          <= '0;
            rd_cnt_q        <= '0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            word_cnt_q      <= word_cnt_d;
            pack_q          <= pack_d;
            wbank_q         <= wbank_d;
            rbank_q         <= rbank_d;
            swap_pending_q  <= swap_pending_d;
            in_ready_q      <= in_ready_d;
            mem_w_addr_q    <= mem_w_addr_d;
            mem_w_data_q    <= mem_w_data_d;
            mem_w_enable_q  <= mem_w_enable_d;
            mem_r_addr_q    <= mem_r_addr_d;
            mem_r_enable_q  <= mem_r_enable_d;
            out_valid_q     <= out_valid_d;
            col_busy_q      <= col_busy_d;
            frame_swapped_q <= frame_swapped_d;
            base_q          <= base_d;
            rd_cnt_q        <= rd_cnt_d;
        end
    end

`ifdef LED_MEM_CTRL_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [1:0]  drop_inc;

    // Saturating count of ignored column triggers and discarded partial words
    always_comb begin
        drop_inc   = 2'd0;
        drop_cnt_d = drop_cnt_q;
        if (col_start && (col_busy_q || !col_ok)) begin
            drop_inc = drop_inc + 2'd1;
        end
        if (accept && in_sof && (byte_cnt_q != 4'd0)) begin
            drop_inc = drop_inc + 2'd1;
        end
        if (({1'b0, drop_cnt_q} + 17'(drop_inc)) > 17'h0FFFF) begin
            drop_cnt_d = 16'hFFFF;
        end else begin
            drop_cnt_d = drop_cnt_q + 16'(drop_inc);
        end
    end

    // Drop counter register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign in_ready      = in_ready_q;
    assign mem_w_addr    = mem_w_addr_q;
    assign mem_w_data    = mem_w_data_q;
    assign mem_w_enable  = mem_w_enable_q;
    assign mem_r_addr    = mem_r_addr_q;
    assign mem_r_enable  = mem_r_enable_q;
    assign out_valid     = out_valid_q;
    assign col_busy      = col_busy_q;
    assign frame_swapped = frame_swapped_q;
    // read data arrives one cycle after the strobe, aligned with out_valid
    assign out_data      = out_valid_q ? mem_r_data : 8'h00;

endmodule
